// File: rtl/stat_dump.sv
// Statistics dumper: walks every monitored port through a stat reader and streams a
// header beat (sequence number) followed by one {frame_count, byte_count} beat per port.
module stat_dump #(
    parameter int unsigned PORT_COUNT        = 4,
    parameter int unsigned PORT_WIDTH        = $clog2(PORT_COUNT),
    parameter int unsigned BYTE_COUNT_WIDTH  = 32,
    parameter int unsigned FRAME_COUNT_WIDTH = 32,
    parameter int unsigned READ_LATENCY      = 1,
    parameter int unsigned INTERVAL_WIDTH    = 32,
    localparam int unsigned DATA_WIDTH       = BYTE_COUNT_WIDTH + FRAME_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [INTERVAL_WIDTH-1:0]    interval,
    input  logic                         trigger,
    input  logic                         clear_on_read,
    output logic [PORT_WIDTH-1:0]        port_select,
    input  logic [BYTE_COUNT_WIDTH-1:0]  byte_count,
    input  logic [FRAME_COUNT_WIDTH-1:0] frame_count,
    output logic [PORT_COUNT-1:0]        port_clear,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic [31:0]                  seq_num
);

    localparam int unsigned WAIT_WIDTH = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(READ_LATENCY);
    localparam logic [PORT_WIDTH-1:0] PORT_LAST = PORT_WIDTH'(PORT_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StSel, StSend} state_e;

    state_e                    state_q;
    logic [PORT_WIDTH-1:0]     sel_q;
    logic [WAIT_WIDTH-1:0]     wait_q;
    logic [DATA_WIDTH-1:0]     tdata_q;
    logic                      tvalid_q;
    logic                      tlast_q;
    logic [31:0]               seq_q;
    logic                      pending_q;
    logic [INTERVAL_WIDTH-1:0] timer_q;
    logic [INTERVAL_WIDTH-1:0] period_q;

    logic [INTERVAL_WIDTH-1:0] period_eff;
    logic                      periodic;
    logic                      start;
    logic                      capture;

    // A new interval value is only picked up when the timer restarts from zero.
    assign period_eff = (timer_q == '0) ? interval : period_q;
    assign periodic   = enable && (period_eff != '0) && (timer_q == period_eff - 1'b1);
    assign start      = pending_q || trigger || periodic;
    assign capture    = (state_q == StSel) && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= '0;
            period_q <= '0;
        end else if (enable && (period_eff != '0)) begin
            if (timer_q == '0) period_q <= interval;
            timer_q <= periodic ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            wait_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            seq_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            // Requests arriving mid-dump collapse into one follow-up dump.
            if ((state_q != StIdle) && (trigger || periodic)) pending_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StHdr;
                        pending_q <= 1'b0;
                        tdata_q   <= DATA_WIDTH'(seq_q);
                        tvalid_q  <= 1'b1;
                        tlast_q   <= 1'b0;
                    end
                end
                StHdr: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        sel_q    <= '0;
                        wait_q   <= '0;
                        state_q  <= StSel;
                    end
                end
                StSel: begin
                    if (capture) begin
                        tdata_q  <= {frame_count, byte_count};
                        tvalid_q <= 1'b1;
                        tlast_q  <= (sel_q == PORT_LAST);
                        state_q  <= StSend;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StSend: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            seq_q   <= seq_q + 1'b1;
                            state_q <= StIdle;
                        end else begin
                            sel_q   <= sel_q + 1'b1;
                            wait_q  <= '0;
                            state_q <= StSel;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        port_clear = '0;
        if (capture && clear_on_read) port_clear[sel_q] = 1'b1;
    end

    assign port_select   = sel_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != StIdle);
    assign seq_num       = seq_q;

endmodule

// File: tb/tb_stat_dump.sv
// Directed bench for stat_dump: triggered, stalled, periodic, clearing, coalesced and reset dumps.
module tb_stat_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] interval;
    logic        trigger;
    logic        clear_on_read;
    logic [1:0]  port_select;
    logic [31:0] byte_count;
    logic [31:0] frame_count;
    logic [3:0]  port_clear;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [31:0] seq_num;

    logic tready_fix;
    logic toggle_mode;
    logic tog;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [64:0] beats[$];
    int          hdr_cyc[$];
    logic [3:0]  pcq[$];
    int          stall_err = 0;
    int          coin_err  = 0;

    stat_dump dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .interval     (interval),
        .trigger      (trigger),
        .clear_on_read(clear_on_read),
        .port_select  (port_select),
        .byte_count   (byte_count),
        .frame_count  (frame_count),
        .port_clear   (port_clear),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .seq_num      (seq_num)
    );

    always #5 clk = ~clk;

    // Stat reader with one cycle of read latency.
    always @(posedge clk) begin
        byte_count  <= 32'd100 + 32'(port_select);
        frame_count <= 32'd10 + 32'(port_select);
    end

    always @(posedge clk) tog <= ~tog;
    assign m_axis_tready = toggle_mode ? tog : tready_fix;

    // Monitor samples at the falling edge; a beat seen here is accepted at the next rising edge.
    logic        hdr_next = 1'b1;
    logic        prev_stall = 1'b0;
    logic        cap_seen = 1'b0;
    logic [64:0] prev_beat;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hdr_next   = 1'b1;
            prev_stall = 1'b0;
            cap_seen   = 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_beat))
                stall_err++;
            if (cap_seen && !m_axis_tvalid) coin_err++;
            cap_seen = (port_clear != 4'b0);
            if (cap_seen) pcq.push_back(port_clear);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back({m_axis_tlast, m_axis_tdata});
                if (hdr_next) hdr_cyc.push_back(cyc);
                hdr_next = m_axis_tlast;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("beat_wait_timeout", 64'(beats.size() >= n), 64'd1);
    endtask

    task automatic chk_dump(input string tag, input int base, input logic [31:0] hdr);
        chk({tag, "_hdr"}, beats[base][63:0], 64'(hdr));
        chk({tag, "_hdr_last"}, 64'(beats[base][64]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] exp = {32'd10 + 32'(i), 32'd100 + 32'(i)};
            chk({tag, "_data"}, beats[base+1+i][63:0], exp);
            chk({tag, "_last"}, 64'(beats[base+1+i][64]), 64'(i == 3));
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; interval = 32'd0; trigger = 1'b0;
        clear_on_read = 1'b0; tready_fix = 1'b1; toggle_mode = 1'b0; tog = 1'b0;
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq", 64'(seq_num), 64'd0);
        chk("rst_sel", 64'(port_select), 64'd0);
        chk("rst_clear", 64'(port_clear), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Periodic dumps every 50 cycles.
        enable = 1'b1; interval = 32'd50;
        wait_beats(15, 250);
        enable = 1'b0; interval = 32'd0;
        repeat (5) step();
        chk_dump("per0", 0, 32'd0);
        chk("per1_hdr", beats[5][63:0], 64'd1);
        chk("per2_hdr", beats[10][63:0], 64'd2);
        chk("per_gap01", 64'(hdr_cyc[1] - hdr_cyc[0]), 64'd50);
        chk("per_gap12", 64'(hdr_cyc[2] - hdr_cyc[1]), 64'd50);
        chk("per_seq", 64'(seq_num), 64'd3);

        // Single triggered dump, no backpressure.
        beats.delete(); pcq.delete();
        pulse_trigger();
        wait_beats(5, 60);
        step();
        chk_dump("trig", 0, 32'd3);
        chk("trig_seq", 64'(seq_num), 64'd4);
        chk("trig_busy", 64'(busy), 64'd0);
        chk("trig_noclear", 64'(pcq.size()), 64'd0);

        // Alternating backpressure.
        beats.delete();
        toggle_mode = 1'b1;
        pulse_trigger();
        wait_beats(5, 100);
        toggle_mode = 1'b0;
        step();
        chk_dump("stall", 0, 32'd4);
        chk("stall_stable", 64'(stall_err), 64'd0);
        chk("stall_seq", 64'(seq_num), 64'd5);

        // Clear-on-read pulses, one per port, coincident with capture.
        beats.delete(); pcq.delete();
        clear_on_read = 1'b1;
        pulse_trigger();
        wait_beats(5, 60);
        clear_on_read = 1'b0;
        step();
        chk("clr_count", 64'(pcq.size()), 64'd4);
        for (int i = 0; i < 4 && i < pcq.size(); i++)
            chk("clr_onehot", 64'(pcq[i]), 64'(4'b0001 << i));
        chk("clr_coincident", 64'(coin_err), 64'd0);

        // Three requests during one dump coalesce into a single follow-up.
        beats.delete();
        pulse_trigger();
        step();
        pulse_trigger(); step();
        pulse_trigger(); step();
        pulse_trigger();
        wait_beats(10, 100);
        repeat (40) step();
        chk("coal_beats", 64'(beats.size()), 64'd10);
        chk("coal_hdr0", beats[0][63:0], 64'd6);
        chk("coal_hdr1", beats[5][63:0], 64'd7);
        chk("coal_seq", 64'(seq_num), 64'd8);

        // Reset while port 2 is being sent.
        beats.delete();
        pulse_trigger();
        wait_beats(3, 40);
        tready_fix = 1'b0;
        for (int k = 0; k < 20 && !(m_axis_tvalid && port_select == 2'd2); k++) step();
        chk("rst_mid_reached", 64'(m_axis_tvalid && port_select == 2'd2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        tready_fix = 1'b1;
        step();
        chk("rst_mid_nobeats", 64'(beats.size()), 64'd3);
        beats.delete();
        pulse_trigger();
        wait_beats(5, 60);
        step();
        chk_dump("post_rst", 0, 32'd0);
        chk("post_rst_seq", 64'(seq_num), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stat_dump.md
STAT_DUMP -- requirements
Module: stat_dump

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 4, number of monitored ports.
REQ-002 SHALL have parameter PORT_WIDTH, default $clog2(PORT_COUNT), port index width.
REQ-003 SHALL have parameter BYTE_COUNT_WIDTH, default 32, byte counter width.
REQ-004 SHALL have parameter FRAME_COUNT_WIDTH, default 32, frame counter width.
REQ-005 SHALL have parameter READ_LATENCY, default 1, clock edges from a port_select change to a valid byte_count/frame_count.
REQ-006 SHALL have parameter INTERVAL_WIDTH, default 32, dump period counter width.
REQ-007 SHALL have local DATA_WIDTH = BYTE_COUNT_WIDTH+FRAME_COUNT_WIDTH.
REQ-008 SHALL have ports as listed, one per line:
clk  in  1  sole clock; one clock, all logic on its rising edge
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  periodic dumping enabled
interval  in  INTERVAL_WIDTH  cycles between periodic dumps; 0 = periodic off
trigger  in  1  one-cycle request for an immediate dump
clear_on_read  in  1  pulse port_clear after each port capture
port_select  out  PORT_WIDTH  port index driven to the stat reader
byte_count  in  BYTE_COUNT_WIDTH  selected port byte count
frame_count  in  FRAME_COUNT_WIDTH  selected port frame count
port_clear  out  PORT_COUNT  per-port counter clear pulse
m_axis_tdata  out  DATA_WIDTH  dump record beat
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  beat accepted
m_axis_tlast  out  1  last beat of dump frame
busy  out  1  dump in progress
seq_num  out  32  completed dump count

Function
REQ-009 SHALL implement FSM states IDLE, HDR, SEL, SEND.
REQ-010 IDLE -> HDR when start condition (REQ-020) holds; busy=1 in every state except IDLE.
REQ-011 HDR: tvalid=1, tdata = seq_num zero-extended, tlast=0; on tvalid&tready -> SEL with port index 0.
REQ-012 SEL: port_select=index; wait counter runs READ_LATENCY+1 cycles, on final cycle byte_count/frame_count captured into tdata {frame_count, byte_count} (frame in MSBs), -> SEND.
REQ-013 On the capture cycle, if clear_on_read=1, port_clear[index] SHALL pulse high exactly one cycle; all other bits 0.
REQ-014 SEND: tvalid=1, tdata held stable, tlast=1 iff index==PORT_COUNT-1; tdata/tlast SHALL not change while tvalid&!tready.
REQ-015 SEND accept with tlast=0 -> SEL, index+1; with tlast=1 -> IDLE, seq_num+1 (wraps 2^32-1 -> 0).
REQ-016 Dump frame length SHALL be exactly PORT_COUNT+1 beats.
REQ-017 tvalid SHALL be 0 in IDLE and SEL; never deasserted before acceptance.
REQ-018 Interval timer: while enable=1 and interval!=0, counts cycles; at count == interval-1 raises periodic request and restarts from 0.
REQ-019 Timer SHALL hold (not reset) while enable=0; interval change takes effect at next restart.
REQ-020 Start condition: pending flag set, or trigger, or periodic request; a dump starts the cycle after in IDLE.
REQ-021 trigger or periodic request while busy SHALL set a single pending flag (coalesced, max one); cleared when the next dump leaves IDLE.
REQ-022 Deasserting enable mid-dump SHALL not abort the dump.
REQ-023 port_select SHALL hold its last value in IDLE and HDR.
REQ-024 Counts incremented between capture and clear are lost; this is accepted behaviour.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM IDLE, port_select 0, port_clear 0, tvalid 0, tlast 0, tdata 0, busy 0, seq_num 0, timer 0, pending 0.
REQ-026 Reset mid-dump SHALL abandon the frame with no further beats; first dump after reset SHALL start with header seq 0.

Verification
REQ-027 PORT_COUNT=4, trigger pulse, tready=1, counts port i = (100+i, 10+i) -> 5 beats: 0, {10,100},{11,101},{12,102},{13,103}, tlast on beat 5, seq_num=1.
REQ-028 Same with tready toggling 0/1 each cycle -> identical beat sequence, tdata stable while stalled.
REQ-029 enable=1, interval=50, no backpressure -> headers start 50 cycles apart, seq 0,1,2.
REQ-030 clear_on_read=1 -> port_clear 0001,0010,0100,1000, one cycle each, coincident with capture.
REQ-031 Three triggers during one dump -> exactly one extra dump follows.
REQ-032 rst_n low during SEND of port 2 -> tvalid 0 immediately; next trigger yields header 0.
